gift_manager: RTL and testbench

Sequences the power-up gift lifecycle for the Arkanoid playfield. A brick hit may spawn one falling gift, chosen from the shared random stream. The block moves the gift down once per frame and detects a paddle catch. A caught gift is converted into a timed effect with start and end pulses. It sits between the brick collision logic, the random generator, the paddle and the renderer/effect consumers.

---
 rtl/gift_pkg.sv | 23 ++
 rtl/gift_effect_timer.sv | 84 ++++++++
 rtl/gift_manager.sv | 109 ++++++++++
 tb/tb_gift_manager.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gift_pkg.sv
// rtl/gift_pkg.sv - gift kinds, FSM encodings and spawn-select mask shared by the gift blocks
package gift_pkg;

  localparam logic [2:0] KIND_INC = 3'd0;
  localparam logic [2:0] KIND_DEC = 3'd1;
  localparam logic [2:0] KIND_SPU = 3'd2;
  localparam logic [2:0] KIND_SPD = 3'd3;
  localparam logic [2:0] KIND_HID = 3'd4;
  localparam logic [2:0] KIND_SOT = 3'd5;
  localparam logic [2:0] KIND_DRP = 3'd6;
  localparam logic [2:0] KIND_MUL = 3'd7;

  typedef enum logic {DROP_IDLE = 1'b0, DROP_FALL = 1'b1} drop_state_t;
  typedef enum logic {EFF_OFF = 1'b0, EFF_ON = 1'b1} eff_state_t;

  // Bits [4:3] both zero gives a one-in-four spawn chance.
  localparam logic [31:0] SPAWN_MASK = 32'h0000_0018;

  function automatic logic spawn_sel(input logic [31:0] rnd);
    return (rnd & SPAWN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/gift_effect_timer.sv
// rtl/gift_effect_timer.sv - timed effect FSM with start/end pulses
// Optional: GIFT_EFFECT_EXTEND_EN makes a same-kind catch extend the running effect.
module gift_effect_timer
  import gift_pkg::*;
#(
  parameter int EFFECT_FRAMES = 600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_lost,
  input  logic       i_catch,
  input  logic [2:0] i_catch_kind,
  output logic [2:0] o_effect_kind,
  output logic       o_effect_on,
  output logic       o_effect_start,
  output logic       o_effect_end
);

  localparam logic [10:0] FRAMES = 11'(EFFECT_FRAMES);
`ifdef GIFT_EFFECT_EXTEND_EN
  localparam logic [11:0] FRAMES_MAX = 12'(2 * EFFECT_FRAMES);
  logic [11:0] w_sum;
`endif

  eff_state_t  r_state, w_state_nxt;
  logic [10:0] r_timer, w_timer_nxt;
  logic [2:0]  r_kind, w_kind_nxt;
  logic        r_start, w_start_nxt;
  logic        r_end, w_end_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= EFF_OFF;
      r_timer <= 11'd0;
      r_kind  <= KIND_INC;
      r_start <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_kind  <= w_kind_nxt;
      r_start <= w_start_nxt;
      r_end   <= w_end_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_kind_nxt  = r_kind;
    w_start_nxt = 1'b0;
    w_end_nxt   = 1'b0;
`ifdef GIFT_EFFECT_EXTEND_EN
    w_sum = {1'b0, r_timer} + {1'b0, FRAMES};
`endif
    if (i_lost) begin
      w_end_nxt   = (r_state == EFF_ON);
      w_state_nxt = EFF_OFF;
      w_timer_nxt = 11'd0;
    end else if (i_catch) begin
      w_state_nxt = EFF_ON;
      w_kind_nxt  = i_catch_kind;
      w_start_nxt = 1'b1;
      w_timer_nxt = FRAMES;
`ifdef GIFT_EFFECT_EXTEND_EN
      if (r_state == EFF_ON && i_catch_kind == r_kind)
        w_timer_nxt = (w_sum > FRAMES_MAX) ? FRAMES_MAX[10:0] : w_sum[10:0];
`endif
    end else if (r_state == EFF_ON && i_tick) begin
      w_timer_nxt = r_timer - 11'd1;
      if (r_timer == 11'd1) begin
        w_state_nxt = EFF_OFF;
        w_end_nxt   = 1'b1;
      end
    end
  end

  assign o_effect_kind  = r_kind;
  assign o_effect_on    = (r_state == EFF_ON);
  assign o_effect_start = r_start;
  assign o_effect_end   = r_end;

endmodule

// File: rtl/gift_manager.sv
// rtl/gift_manager.sv - falling gift drop FSM and paddle catch geometry
// Optional: GIFT_EFFECT_EXTEND_EN (handled inside gift_effect_timer).
module gift_manager
  import gift_pkg::*;
#(
  parameter int GIFT_SZ       = 16,
  parameter int PD_W          = 64,
  parameter int PD_H          = 10,
  parameter int SCREEN_H      = 480,
  parameter int FALL_STEP     = 2,
  parameter int EFFECT_FRAMES = 600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        lost,
  input  logic        brick_hit,
  input  logic [9:0]  brick_x,
  input  logic [9:0]  brick_y,
  input  logic [31:0] rand_num,
  input  logic [9:0]  paddle_x,
  input  logic [9:0]  paddle_y,
  output logic [2:0]  kind,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        active,
  output logic [2:0]  effect_kind,
  output logic        effect_on,
  output logic        effect_start,
  output logic        effect_end
);

  drop_state_t r_state, w_state_nxt;
  logic [2:0]  r_kind, w_kind_nxt;
  logic [9:0]  r_x, w_x_nxt;
  logic [9:0]  r_y, w_y_nxt;
  logic        w_catch;
  logic        w_over_h, w_over_v;
  logic [10:0] w_y_step;

  // 11-bit geometry so positions near 1023 never wrap.
  assign w_over_h = ({1'b0, r_x} < {1'b0, paddle_x} + 11'(PD_W)) &&
                    ({1'b0, paddle_x} < {1'b0, r_x} + 11'(GIFT_SZ));
  assign w_over_v = ({1'b0, r_y} + 11'(GIFT_SZ) >= {1'b0, paddle_y}) &&
                    ({1'b0, r_y} <= {1'b0, paddle_y} + 11'(PD_H));
  assign w_y_step = {1'b0, r_y} + 11'(FALL_STEP);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= DROP_IDLE;
      r_kind  <= KIND_INC;
      r_x     <= 10'd0;
      r_y     <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      r_kind  <= w_kind_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kind_nxt  = r_kind;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_catch     = 1'b0;
    if (lost) begin
      w_state_nxt = DROP_IDLE;
    end else if (r_state == DROP_IDLE) begin
      if (brick_hit && spawn_sel(rand_num)) begin
        w_state_nxt = DROP_FALL;
        w_kind_nxt  = rand_num[2:0];
        w_x_nxt     = brick_x;
        w_y_nxt     = brick_y;
      end
    end else if (tick) begin
      if (w_over_h && w_over_v) begin
        w_catch     = 1'b1;
        w_state_nxt = DROP_IDLE;
      end else if (w_y_step >= 11'(SCREEN_H)) begin
        w_state_nxt = DROP_IDLE;
      end else begin
        w_y_nxt = w_y_step[9:0];
      end
    end
  end

  assign kind   = r_kind;
  assign o_x    = r_x;
  assign o_y    = r_y;
  assign active = (r_state == DROP_FALL);

  gift_effect_timer #(
    .EFFECT_FRAMES (EFFECT_FRAMES)
  ) u_effect (
    .clock          (clock),
    .reset          (reset),
    .i_tick         (tick),
    .i_lost         (lost),
    .i_catch        (w_catch),
    .i_catch_kind   (r_kind),
    .o_effect_kind  (effect_kind),
    .o_effect_on    (effect_on),
    .o_effect_start (effect_start),
    .o_effect_end   (effect_end)
  );

endmodule

// File: tb/tb_gift_manager.sv
// tb/tb_gift_manager.sv - self-checking bench for gift_manager (EFFECT_FRAMES=3)
module tb_gift_manager;

  localparam int EF = 3;
`ifdef GIFT_EFFECT_EXTEND_EN
  localparam int RESTART_TICKS = 4;
`else
  localparam int RESTART_TICKS = 3;
`endif

  logic        clock = 1'b0;
  logic        reset, tick, lost, brick_hit;
  logic [9:0]  brick_x, brick_y, paddle_x, paddle_y;
  logic [31:0] rand_num;
  logic [2:0]  kind, effect_kind;
  logic [9:0]  o_x, o_y;
  logic        active, effect_on, effect_start, effect_end;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  gift_manager #(.EFFECT_FRAMES(EF)) dut (
    .clock(clock), .reset(reset), .tick(tick), .lost(lost),
    .brick_hit(brick_hit), .brick_x(brick_x), .brick_y(brick_y),
    .rand_num(rand_num), .paddle_x(paddle_x), .paddle_y(paddle_y),
    .kind(kind), .o_x(o_x), .o_y(o_y), .active(active),
    .effect_kind(effect_kind), .effect_on(effect_on),
    .effect_start(effect_start), .effect_end(effect_end)
  );

  typedef struct {
    logic        rst, hit, lst, tck;
    logic [31:0] rnd;
    logic [9:0]  bx, by;
    logic        e_act;
    logic [2:0]  e_kind;
    logic [9:0]  e_x, e_y;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  task automatic spawn(input logic [31:0] r, input logic [9:0] x, input logic [9:0] y);
    brick_hit = 1'b1; rand_num = r; brick_x = x; brick_y = y;
    cycle();
    brick_hit = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int seen;
    reset = 1'b1; tick = 1'b0; lost = 1'b0; brick_hit = 1'b0;
    brick_x = '0; brick_y = '0; rand_num = '0;
    paddle_x = 10'd400; paddle_y = 10'd460;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        10'd0,   10'd0,  1'b0, 3'd0, 10'd0,   10'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8,        10'd100, 10'd50, 1'b0, 3'd0, 10'd0,   10'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h5,        10'd100, 10'd50, 1'b1, 3'd5, 10'd100, 10'd50};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        10'd200, 10'd60, 1'b1, 3'd5, 10'd100, 10'd50};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        10'd0,   10'd0,  1'b1, 3'd5, 10'd100, 10'd52};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        10'd200, 10'd60, 1'b0, 3'd5, 10'd100, 10'd52};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFE7, 10'd5,  10'd6,  1'b1, 3'd7, 10'd5,   10'd6};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        10'd0,   10'd0,  1'b0, 3'd7, 10'd5,   10'd6};

    cycle();
    cycle();
    for (int i = 0; i < 8; i++) begin
      reset = vecs[i].rst; brick_hit = vecs[i].hit; lost = vecs[i].lst; tick = vecs[i].tck;
      rand_num = vecs[i].rnd; brick_x = vecs[i].bx; brick_y = vecs[i].by;
      cycle();
      reset = 1'b0; brick_hit = 1'b0; lost = 1'b0; tick = 1'b0;
      chk($sformatf("vec%0d_active", i), 32'(active), 32'(vecs[i].e_act));
      chk($sformatf("vec%0d_kind", i),   32'(kind),   32'(vecs[i].e_kind));
      chk($sformatf("vec%0d_x", i),      32'(o_x),    32'(vecs[i].e_x));
      chk($sformatf("vec%0d_y", i),      32'(o_y),    32'(vecs[i].e_y));
      chk($sformatf("vec%0d_eff", i),    32'({effect_on, effect_start, effect_end}), 32'(0));
    end

    // Fall and miss at the bottom edge.
    do_reset();
    paddle_x = 10'd400; paddle_y = 10'd460;
    spawn(32'h5, 10'd100, 10'd470);
    for (int t = 0; t < 4; t++) do_tick();
    chk("miss_y478", 32'(o_y), 32'd478);
    chk("miss_active_before", 32'(active), 32'd1);
    do_tick();
    chk("miss_active", 32'(active), 32'd0);
    chk("miss_no_start", 32'({effect_start, effect_on}), 32'd0);

    // Catch: overlap first reached at o_y=424 (424+16 >= 440).
    do_reset();
    paddle_x = 10'd290; paddle_y = 10'd440;
    spawn(32'h6, 10'd300, 10'd420);
    do_tick();
    chk("catch_y422", 32'(o_y), 32'd422);
    do_tick();
    chk("catch_y424", 32'(o_y), 32'd424);
    chk("catch_still_active", 32'({active, effect_on}), 32'b10);
    do_tick();
    chk("catch_active", 32'(active), 32'd0);
    chk("catch_start", 32'(effect_start), 32'd1);
    chk("catch_on", 32'(effect_on), 32'd1);
    chk("catch_ekind", 32'(effect_kind), 32'd6);
    chk("catch_y_held", 32'(o_y), 32'd424);
    cycle();
    chk("catch_start_1cyc", 32'({effect_start, effect_on}), 32'b01);

    // Expiry after exactly EF ticks.
    do_tick();
    do_tick();
    chk("exp_still_on", 32'({effect_on, effect_end}), 32'b10);
    do_tick();
    chk("exp_end", 32'(effect_end), 32'd1);
    chk("exp_off", 32'(effect_on), 32'd0);
    chk("exp_no_start", 32'(effect_start), 32'd0);
    cycle();
    chk("exp_end_1cyc", 32'(effect_end), 32'd0);

    // Restart/extend: same kind caught with one tick left.
    do_reset();
    spawn(32'h0, 10'd300, 10'd424);
    do_tick();
    chk("rs_first_start", 32'(effect_start), 32'd1);
    do_tick();
    do_tick();
    chk("rs_on_t1", 32'({effect_on, effect_end}), 32'b10);
    spawn(32'h0, 10'd300, 10'd424);
    do_tick();
    chk("rs_restart_start", 32'(effect_start), 32'd1);
    chk("rs_restart_no_end", 32'(effect_end), 32'd0);
    chk("rs_on", 32'(effect_on), 32'd1);
    seen = 0;
    for (int t = 1; t <= 6; t++) begin
      do_tick();
      if (effect_end && seen == 0) seen = t;
    end
    chk("rs_length", 32'(seen), 32'(RESTART_TICKS));

    // Abort with lost while falling and ON; simultaneous brick_hit ignored.
    do_reset();
    spawn(32'h0, 10'd300, 10'd424);
    do_tick();
    paddle_x = 10'd400; paddle_y = 10'd460;
    spawn(32'h0, 10'd100, 10'd100);
    chk("ab_falling_on", 32'({active, effect_on}), 32'b11);
    lost = 1'b1; brick_hit = 1'b1; rand_num = 32'h0; brick_x = 10'd10; brick_y = 10'd10;
    cycle();
    lost = 1'b0; brick_hit = 1'b0;
    chk("ab_active", 32'(active), 32'd0);
    chk("ab_off", 32'(effect_on), 32'd0);
    chk("ab_end", 32'(effect_end), 32'd1);
    cycle();
    chk("ab_no_spawn", 32'({active, effect_end}), 32'd0);
    lost = 1'b1;
    cycle();
    lost = 1'b0;
    chk("ab_lost_off_no_end", 32'(effect_end), 32'd0);

    // Reset mid-effect is silent.
    paddle_x = 10'd290; paddle_y = 10'd440;
    spawn(32'h3, 10'd300, 10'd424);
    do_tick();
    chk("rst_mid_on", 32'(effect_on), 32'd1);
    do_reset();
    chk("rst_mid_silent", 32'({effect_on, effect_end, effect_start, active}), 32'd0);
    chk("rst_mid_kind", 32'({effect_kind, kind}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
